rvfi_retire_sequencer: RTL and testbench

//  Buffers RVFI retirement packets from the core under test and releases them in order to the

---
 rtl/rvfi_seq_pkg.sv | 34 +++
 rtl/rvfi_sync_fifo.sv | 54 +++++
 rtl/rvfi_retire_sequencer.sv | 98 +++++++++
 tb/tb_rvfi_retire_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_seq_pkg.sv
// Shared types for the RVFI retirement sequencer: the packed retirement packet
// and the run-sequencing FSM states.
package rvfi_seq_pkg;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_pkt_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } seq_state_t;

endpackage

// File: rtl/rvfi_sync_fifo.sv
// Synchronous FIFO for retirement packets. Head is registered storage only (no
// write-through), and reads as zero while empty.
module rvfi_sync_fifo
    import rvfi_seq_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type pkt_t = rvfi_pkt_t,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  pkt_t        push_data_i,
    input  logic        pop_i,
    output pkt_t        head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);

    pkt_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A write into a full FIFO is legal only when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// Captures RVFI retirements into a FIFO for the checker, checks order continuity,
// watches for stalls and sequences the run IDLE -> RUN -> DRAIN -> DONE / ERROR.
module rvfi_retire_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int CHECK_ORDER = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  rvfi_pkt_t                in_pkt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output rvfi_pkt_t                out_pkt,
    output seq_state_t               state,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [63:0]              retired,
    output logic                     err_overflow,
    output logic                     err_order,
    output logic                     err_timeout
);

    seq_state_t  state_q, state_d;
    logic [63:0] exp_order_q, retired_q;
    logic [31:0] wd_q, wd_d;
    logic        err_ovf_q, err_ord_q, err_to_q;
    logic        accept, pop, full, empty;
    logic        ovf_hit, ord_hit, wd_hit, any_err;

    assign accept  = in_valid && (state_q == RUN);
    assign pop     = out_valid && out_ready;
    assign ovf_hit = accept && full && !pop;
    assign ord_hit = (CHECK_ORDER != 0) && accept && (in_pkt.order != exp_order_q);
    assign wd_hit  = (TIMEOUT != 0) && (state_q == RUN) && !accept
                     && (wd_q + 32'd1 == 32'(TIMEOUT));
    assign any_err = ovf_hit || ord_hit || wd_hit;

    rvfi_sync_fifo #(.DEPTH(DEPTH), .pkt_t(rvfi_pkt_t)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .push_data_i (in_pkt),
        .pop_i       (pop),
        .head_o      (out_pkt),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (fill)
    );

    assign out_valid    = !empty;
    assign state        = state_q;
    assign retired      = retired_q;
    assign err_overflow = err_ovf_q;
    assign err_order    = err_ord_q;
    assign err_timeout  = err_to_q;

    always_comb begin
        state_d = state_q;
        wd_d    = (state_q != RUN || accept) ? 32'd0 : wd_q + 32'd1;
        case (state_q)
            IDLE:  if (enable) state_d = RUN;
            RUN: begin
                // Errors outrank a halting packet and a disable in the same cycle.
                if (any_err)                    state_d = ERROR;
                else if (accept && in_pkt.halt) state_d = DRAIN;
                else if (!enable)               state_d = IDLE;
            end
            DRAIN: if (empty) state_d = DONE;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            exp_order_q <= '0;
            retired_q   <= '0;
            wd_q        <= '0;
            err_ovf_q   <= 1'b0;
            err_ord_q   <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            err_ovf_q <= err_ovf_q | ovf_hit;
            err_ord_q <= err_ord_q | ord_hit;
            err_to_q  <= err_to_q | wd_hit;
            if (accept) begin
                exp_order_q <= in_pkt.order + 64'd1;
                retired_q   <= retired_q + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// Directed bench: stimulus queues the packets it expects to come out, a negedge
// monitor pops and compares on every out_valid/out_ready handshake.
module tb_rvfi_retire_sequencer;
    import rvfi_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       in_valid = 1'b0;
    rvfi_pkt_t  in_pkt = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    rvfi_pkt_t  out_pkt;
    seq_state_t state;
    logic [3:0] fill;
    logic [63:0] retired;
    logic       err_overflow, err_order, err_timeout;

    int n_checks = 0;
    int n_errors = 0;
    rvfi_pkt_t sb[$];
    rvfi_pkt_t mon_exp;

    always #5 clk = ~clk;

    rvfi_retire_sequencer #(.DEPTH(8), .CHECK_ORDER(1), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_pkt(in_pkt),
        .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt), .state(state),
        .fill(fill), .retired(retired), .err_overflow(err_overflow), .err_order(err_order),
        .err_timeout(err_timeout)
    );

    function automatic rvfi_pkt_t mk(input logic [63:0] ord, input logic halt);
        rvfi_pkt_t p;
        p = '0;
        p.order    = ord;
        p.insn     = {16'hA5C3, ord[15:0]};
        p.pc_rdata = 32'h8000_0000 + {ord[29:0], 2'b00};
        p.pc_wdata = p.pc_rdata + 32'd4;
        p.rd_addr  = ord[4:0];
        p.halt     = halt;
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0h required %0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] ord, input logic halt, input bit stored);
        in_valid = 1'b1;
        in_pkt   = mk(ord, halt);
        if (stored) sb.push_back(in_pkt);
        step();
        in_valid = 1'b0;
        in_pkt   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pkt = '0;
        step(); step();
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 64) begin step(); n++; end
        chk({name, "_drained"}, 64'(sb.size()), 64'd0);
        chk({name, "_fill0"}, 64'(fill), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected got order %0d required no output", out_pkt.order);
            end else begin
                mon_exp = sb.pop_front();
                if (out_pkt !== mon_exp) begin
                    n_errors++;
                    $display("FAIL sb_pkt got order %0d insn %h required order %0d insn %h",
                             out_pkt.order, out_pkt.insn, mon_exp.order, mon_exp.insn);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int w;
        do_reset();
        chk("rst_state", 64'(state), 64'(IDLE));
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pkt_order", out_pkt.order, 64'd0);
        chk("rst_retired", retired, 64'd0);
        chk("rst_errs", {61'd0, err_overflow, err_order, err_timeout}, 64'd0);

        // 1: back-to-back 0..4, checker always ready
        out_ready = 1'b1; enable = 1'b1; step();
        chk("t1_run", 64'(state), 64'(RUN));
        send(0, 1'b0, 1'b1);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_latency_order", out_pkt.order, 64'd0);
        for (int i = 1; i < 5; i++) send(64'(i), 1'b0, 1'b1);
        enable = 1'b0; step();
        chk("t1_retired", retired, 64'd5);
        chk("t1_errs", {61'd0, err_overflow, err_order, err_timeout}, 64'd0);
        chk("t1_idle", 64'(state), 64'(IDLE));
        wait_drain("t1");

        // 2: overflow with checker stalled, then drain the 8 stored packets
        do_reset();
        enable = 1'b1; step();
        for (int i = 0; i < 8; i++) send(64'(i), 1'b0, 1'b1);
        chk("t2_full_noerr", 64'(err_overflow), 64'd0);
        send(8, 1'b0, 1'b0);
        chk("t2_overflow", 64'(err_overflow), 64'd1);
        chk("t2_state", 64'(state), 64'(ERROR));
        chk("t2_fill", 64'(fill), 64'd8);
        chk("t2_order_ok", 64'(err_order), 64'd0);
        out_ready = 1'b1;
        wait_drain("t2");
        chk("t2_error_held", 64'(state), 64'(ERROR));

        // 3: order gap 0,1,3
        do_reset();
        out_ready = 1'b1; enable = 1'b1; step();
        send(0, 1'b0, 1'b1);
        send(1, 1'b0, 1'b1);
        chk("t3_no_err_yet", 64'(err_order), 64'd0);
        send(3, 1'b0, 1'b1);
        chk("t3_err_order", 64'(err_order), 64'd1);
        chk("t3_state", 64'(state), 64'(ERROR));
        chk("t3_no_ovf", 64'(err_overflow), 64'd0);
        wait_drain("t3");

        // 4: halt on order 2, drain held while checker stalls
        do_reset();
        enable = 1'b1; step();
        send(0, 1'b0, 1'b1);
        send(1, 1'b0, 1'b1);
        send(2, 1'b1, 1'b1);
        chk("t4_drain", 64'(state), 64'(DRAIN));
        chk("t4_fill", 64'(fill), 64'd3);
        step(); step();
        send(3, 1'b0, 1'b0);
        chk("t4_drain_held", 64'(state), 64'(DRAIN));
        chk("t4_drain_no_accept", retired, 64'd3);
        chk("t4_fill_held", 64'(fill), 64'd3);
        out_ready = 1'b1;
        w = 0;
        while (state != DONE && w < 20) begin step(); w++; end
        chk("t4_done", 64'(state), 64'(DONE));
        chk("t4_done_fill", 64'(fill), 64'd0);
        send(3, 1'b0, 1'b0);
        step();
        chk("t4_done_ignored", retired, 64'd3);
        chk("t4_done_held", 64'(state), 64'(DONE));
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // 5: watchdog fires exactly after 16 idle RUN cycles
        do_reset();
        enable = 1'b1; step();
        for (int i = 0; i < 15; i++) step();
        chk("t5_before", 64'(err_timeout), 64'd0);
        chk("t5_before_state", 64'(state), 64'(RUN));
        step();
        chk("t5_timeout", 64'(err_timeout), 64'd1);
        chk("t5_state", 64'(state), 64'(ERROR));

        // 6: push+pop while full, then reset mid-RUN
        do_reset();
        enable = 1'b1; step();
        for (int i = 0; i < 8; i++) send(64'(i), 1'b0, 1'b1);
        out_ready = 1'b1;
        send(8, 1'b0, 1'b1);
        chk("t6_fill", 64'(fill), 64'd8);
        chk("t6_no_ovf", 64'(err_overflow), 64'd0);
        send(9, 1'b0, 1'b1);
        chk("t6_fill2", 64'(fill), 64'd8);
        chk("t6_run", 64'(state), 64'(RUN));
        out_ready = 1'b0;
        reset = 1'b1; step();
        sb.delete();
        chk("t6_rst_state", 64'(state), 64'(IDLE));
        chk("t6_rst_fill", 64'(fill), 64'd0);
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_pkt", out_pkt.order, 64'd0);
        chk("t6_rst_retired", retired, 64'd0);
        chk("t6_rst_errs", {61'd0, err_overflow, err_order, err_timeout}, 64'd0);
        reset = 1'b0;
        // exp_order returned to 0: a fresh order-0 packet must not flag
        out_ready = 1'b1; enable = 1'b1; step();
        send(0, 1'b0, 1'b1);
        chk("t6_exp_order_reset", 64'(err_order), 64'd0);
        enable = 1'b0;
        wait_drain("t6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
